// File: rtl/fault_syndrome_collector_pkg.sv
// Shared types and constants for the fault-dictionary syndrome collector.
package fdict_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } fsc_state_e;

    localparam int DEF_OUT_W   = 123;
    localparam int DEF_NUM_PAT = 117;
    localparam int DEF_NUM_CH  = 1;
    localparam int DEF_FID_W   = 16;

    // A channel that never mismatched reports one past the last pattern index.
    function automatic int unsigned not_detected_code(input int unsigned num_pat);
        return num_pat;
    endfunction

endpackage

// File: rtl/fault_syndrome_collector_if.sv
// Session bus of the syndrome collector: start, pattern-response and record channels.
interface fault_syndrome_collector_if #(
    parameter int OUT_W   = 123,
    parameter int NUM_PAT = 117,
    parameter int NUM_CH  = 1,
    parameter int FID_W   = 16
);
    localparam int IDX_W = $clog2(NUM_PAT + 1);

    // Every channel transfers on a cycle where valid (start/pat_valid/rec_valid) and
    // ready are both high; payload must be stable while valid waits for ready.
    logic                      start;
    logic                      start_ready;
    logic [FID_W-1:0]          fault_id;
    logic [OUT_W-1:0]          cmp_mask;
    logic                      pat_valid;
    logic                      pat_ready;
    logic [OUT_W-1:0]          golden;
    logic [NUM_CH*OUT_W-1:0]   faulty;
    logic                      rec_valid;
    logic                      rec_ready;
    logic [FID_W-1:0]          rec_fault_id;
    logic [NUM_CH*NUM_PAT-1:0] rec_syndrome;
    logic [NUM_CH-1:0]         rec_detected;
    logic [NUM_CH*IDX_W-1:0]   rec_first_idx;
    logic                      busy;

    modport master (
        output start, fault_id, cmp_mask, pat_valid, golden, faulty, rec_ready,
        input  start_ready, pat_ready, rec_valid, rec_fault_id, rec_syndrome,
               rec_detected, rec_first_idx, busy
    );

    modport slave (
        input  start, fault_id, cmp_mask, pat_valid, golden, faulty, rec_ready,
        output start_ready, pat_ready, rec_valid, rec_fault_id, rec_syndrome,
               rec_detected, rec_first_idx, busy
    );

endinterface

// File: rtl/fault_syndrome_collector_cmp_lane.sv
// One faulty-copy channel: masked compare, per-pattern syndrome, detected flag, first index.
module fdict_cmp_lane
    import fdict_pkg::*;
#(
    parameter int OUT_W   = DEF_OUT_W,
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int IDX_W   = $clog2(NUM_PAT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [OUT_W-1:0]   golden_i,
    input  logic [OUT_W-1:0]   faulty_i,
    input  logic [OUT_W-1:0]   mask_i,
    output logic [NUM_PAT-1:0] syndrome_o,
    output logic               detected_o,
    output logic [IDX_W-1:0]   first_idx_o
);
    localparam logic [IDX_W-1:0] ND_IDX = IDX_W'(not_detected_code(NUM_PAT));

    logic [NUM_PAT-1:0] syn_q, syn_d;
    logic               det_q, det_d;
    logic [IDX_W-1:0]   fi_q, fi_d;
    logic               mis;

    assign mis = |((golden_i ^ faulty_i) & mask_i);

    always_comb begin
        syn_d = syn_q;
        det_d = det_q;
        fi_d  = fi_q;
        if (clr_i) begin
            syn_d = '0;
            det_d = 1'b0;
            fi_d  = ND_IDX;
        end else if (we_i) begin
            // Decoded write keeps the index compare at IDX_W, which can exceed the select width.
            for (int i = 0; i < NUM_PAT; i++) begin
                if (idx_i == IDX_W'(i)) syn_d[i] = mis;
            end
            if (mis && !det_q) begin
                det_d = 1'b1;
                fi_d  = idx_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            syn_q <= '0;
            det_q <= 1'b0;
            fi_q  <= ND_IDX;
        end else begin
            syn_q <= syn_d;
            det_q <= det_d;
            fi_q  <= fi_d;
        end
    end

    assign syndrome_o  = syn_q;
    assign detected_o  = det_q;
    assign first_idx_o = fi_q;

endmodule

// File: rtl/fault_syndrome_collector.sv
// Session FSM, pattern counter and record assembly for the fault syndrome collector.
module fault_syndrome_collector
    import fdict_pkg::*;
#(
    parameter int OUT_W   = DEF_OUT_W,
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int FID_W   = DEF_FID_W
) (
    input  logic                       clk,
    input  logic                       rst,
    fault_syndrome_collector_if.slave  bus,
    output fsc_state_e                 dbg_state_o
);
    localparam int               IDX_W    = $clog2(NUM_PAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAT - 1);

    fsc_state_e       state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [FID_W-1:0] fid_q;
    logic [OUT_W-1:0] mask_q;

    logic start_hs;
    logic pat_hs;

    assign start_hs = (state_q == ST_IDLE) && bus.start;
    assign pat_hs   = (state_q == ST_COLLECT) && bus.pat_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fid_q   <= '0;
            mask_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= '0;
                        fid_q   <= bus.fault_id;
                        mask_q  <= bus.cmp_mask;
                    end
                end
                ST_COLLECT: begin
                    if (bus.pat_valid) begin
                        cnt_q <= cnt_q + IDX_W'(1);
                        if (cnt_q == LAST_IDX) state_q <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (bus.rec_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [NUM_PAT-1:0] syn_w [NUM_CH];
    logic               det_w [NUM_CH];
    logic [IDX_W-1:0]   fi_w  [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        fdict_cmp_lane #(
            .OUT_W   (OUT_W),
            .NUM_PAT (NUM_PAT),
            .IDX_W   (IDX_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (start_hs),
            .we_i        (pat_hs),
            .idx_i       (cnt_q),
            .golden_i    (bus.golden),
            .faulty_i    (bus.faulty[c*OUT_W +: OUT_W]),
            .mask_i      (mask_q),
            .syndrome_o  (syn_w[c]),
            .detected_o  (det_w[c]),
            .first_idx_o (fi_w[c])
        );
    end

    logic [NUM_CH*NUM_PAT-1:0] syn_flat;
    logic [NUM_CH-1:0]         det_flat;
    logic [NUM_CH*IDX_W-1:0]   fi_flat;

    always_comb begin
        syn_flat = '0;
        det_flat = '0;
        fi_flat  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            syn_flat[c*NUM_PAT +: NUM_PAT] = syn_w[c];
            det_flat[c]                    = det_w[c];
            fi_flat[c*IDX_W +: IDX_W]      = fi_w[c];
        end
    end

    assign bus.start_ready   = (state_q == ST_IDLE);
    assign bus.pat_ready     = (state_q == ST_COLLECT);
    assign bus.rec_valid     = (state_q == ST_REPORT);
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.rec_fault_id  = fid_q;
    assign bus.rec_syndrome  = syn_flat;
    assign bus.rec_detected  = det_flat;
    assign bus.rec_first_idx = fi_flat;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_fault_syndrome_collector.sv
// Self-checking bench for fault_syndrome_collector (OUT_W=8, NUM_PAT=4, NUM_CH=2).
module tb_fault_syndrome_collector;
    import fdict_pkg::*;

    localparam int OUT_W   = 8;
    localparam int NUM_PAT = 4;
    localparam int NUM_CH  = 2;
    localparam int FID_W   = 16;
    localparam int REC_W   = FID_W + NUM_CH*NUM_PAT + NUM_CH + NUM_CH*3;

    logic       clk = 1'b0;
    logic       rst;
    fsc_state_e dbg_state;

    always #5 clk = ~clk;

    fault_syndrome_collector_if #(
        .OUT_W(OUT_W), .NUM_PAT(NUM_PAT), .NUM_CH(NUM_CH), .FID_W(FID_W)
    ) bus ();

    fault_syndrome_collector #(
        .OUT_W(OUT_W), .NUM_PAT(NUM_PAT), .NUM_CH(NUM_CH), .FID_W(FID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    logic [REC_W-1:0] exp_q[$];

    typedef struct packed {
        logic [15:0] fid;
        logic [7:0]  mask;
        logic [31:0] g;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [7:0]  syn;
        logic [1:0]  det;
        logic [5:0]  fi;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flips are XOR patterns: faulty = golden ^ flip, per pattern byte.
    function automatic logic [REC_W-1:0] model(input logic [15:0] fid, input logic [7:0] mask,
                                               input logic [31:0] g, input logic [31:0] f0,
                                               input logic [31:0] f1);
        logic [7:0]  syn;
        logic [1:0]  det;
        logic [5:0]  fi;
        logic [31:0] flip;
        logic [7:0]  gold_b;
        logic [7:0]  fault_b;
        int          first;
        syn = '0;
        det = '0;
        fi  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            flip  = (c == 0) ? f0 : f1;
            first = NUM_PAT;
            for (int k = 0; k < NUM_PAT; k++) begin
                gold_b  = g[k*8 +: 8];
                fault_b = gold_b ^ flip[k*8 +: 8];
                if (((gold_b ^ fault_b) & mask) != 8'h00) begin
                    syn[c*NUM_PAT + k] = 1'b1;
                    if (first == NUM_PAT) first = k;
                end
            end
            det[c]        = (first != NUM_PAT);
            fi[c*3 +: 3]  = 3'(first);
        end
        return {fid, syn, det, fi};
    endfunction

    task automatic check_record(input string tag, input logic [REC_W-1:0] e);
        check({tag, ".fault_id"},  64'(bus.rec_fault_id),  64'(e[31:16]));
        check({tag, ".syndrome"},  64'(bus.rec_syndrome),  64'(e[15:8]));
        check({tag, ".detected"},  64'(bus.rec_detected),  64'(e[7:6]));
        check({tag, ".first_idx"}, 64'(bus.rec_first_idx), 64'(e[5:0]));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".state"},       64'(dbg_state),       64'(ST_IDLE));
        check({tag, ".start_ready"}, 64'(bus.start_ready), 64'd1);
        check({tag, ".busy"},        64'(bus.busy),        64'd0);
        check({tag, ".pat_ready"},   64'(bus.pat_ready),   64'd0);
        check({tag, ".rec_valid"},   64'(bus.rec_valid),   64'd0);
        check_record(tag, {16'h0000, 8'h00, 2'b00, 3'd4, 3'd4});
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.pat_valid = 1'b0;
        bus.rec_ready = 1'b0;
        bus.fault_id  = 16'($urandom);
        bus.cmp_mask  = 8'($urandom);
        bus.golden    = 8'($urandom);
        bus.faulty    = 16'($urandom);
    endtask

    task automatic run_session(input logic [15:0] fid, input logic [7:0] mask,
                               input logic [31:0] g, input logic [31:0] f0, input logic [31:0] f1,
                               input bit gaps, input int hold,
                               input logic [REC_W-1:0] exp, input string tag);
        logic [REC_W-1:0] e;
        logic [7:0]       gb;
        exp_q.push_back(exp);
        bus.start    = 1'b1;
        bus.fault_id = fid;
        bus.cmp_mask = mask;
        step();
        // Scramble the session inputs to show they were latched on the handshake.
        idle_inputs();
        check({tag, ".pat_ready_rise"}, 64'(bus.pat_ready), 64'd1);
        for (int k = 0; k < NUM_PAT; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.pat_valid = 1'b0;
                    bus.golden    = 8'($urandom);
                    bus.faulty    = 16'($urandom);
                    step();
                    check({tag, ".pat_ready_stall"}, 64'(bus.pat_ready), 64'd1);
                end
            end
            check({tag, ".rec_valid_early"}, 64'(bus.rec_valid), 64'd0);
            gb            = g[k*8 +: 8];
            bus.pat_valid = 1'b1;
            bus.golden    = gb;
            bus.faulty    = {gb ^ f1[k*8 +: 8], gb ^ f0[k*8 +: 8]};
            step();
        end
        idle_inputs();
        check({tag, ".rec_valid"},   64'(bus.rec_valid),   64'd1);
        check({tag, ".start_ready"}, 64'(bus.start_ready), 64'd0);
        check({tag, ".busy"},        64'(bus.busy),        64'd1);
        e = exp_q.pop_front();
        check_record(tag, e);
        for (int h = 0; h < hold; h++) begin
            bus.start     = 1'($urandom_range(0, 1));
            bus.pat_valid = 1'($urandom_range(0, 1));
            bus.golden    = 8'($urandom);
            bus.faulty    = 16'($urandom);
            step();
            check({tag, ".hold_pat_ready"},   64'(bus.pat_ready),   64'd0);
            check({tag, ".hold_start_ready"}, 64'(bus.start_ready), 64'd0);
            check({tag, ".hold_rec_valid"},   64'(bus.rec_valid),   64'd1);
            check_record({tag, ".hold"}, e);
        end
        // Record handshake with a start that must be ignored in the same cycle.
        bus.rec_ready = 1'b1;
        bus.start     = 1'b1;
        bus.pat_valid = 1'b0;
        step();
        idle_inputs();
        check({tag, ".post_start_ready"}, 64'(bus.start_ready), 64'd1);
        check({tag, ".post_busy"},        64'(bus.busy),        64'd0);
        check({tag, ".post_rec_valid"},   64'(bus.rec_valid),   64'd0);
        check({tag, ".post_pat_ready"},   64'(bus.pat_ready),   64'd0);
        check_record({tag, ".idle"}, e);
    endtask

    initial begin
        logic [15:0] rfid;
        logic [7:0]  rmask;
        logic [31:0] rg, rf0, rf1;
        vec_t        v;

        //            fid       mask   golden        flip ch0      flip ch1      syn    det    fi {ch1,ch0}
        vecs[0] = '{16'h1111, 8'hFF, 32'hC35A963C, 32'h00000000, 32'h00000000, 8'h00, 2'b00, {3'd4, 3'd4}};
        vecs[1] = '{16'hA5A5, 8'hFF, 32'hC35A963C, 32'h01008000, 32'h00000000, 8'h0A, 2'b01, {3'd4, 3'd1}};
        vecs[2] = '{16'h0B05, 8'hDF, 32'hC35A963C, 32'h20202020, 32'h00000000, 8'h00, 2'b00, {3'd4, 3'd4}};
        vecs[3] = '{16'h0B05, 8'hFF, 32'hC35A963C, 32'h20202020, 32'h00000000, 8'h0F, 2'b01, {3'd4, 3'd0}};
        vecs[4] = '{16'h00C2, 8'hFF, 32'h12345678, 32'h00040000, 32'h00000000, 8'h04, 2'b01, {3'd4, 3'd2}};
        vecs[5] = '{16'hBEEF, 8'h0F, 32'h9ABCDEF0, 32'h0FF0F0F0, 32'h01020408, 8'hF8, 2'b11, {3'd0, 3'd3}};
        vecs[6] = '{16'hFFFF, 8'h00, 32'h00FF00FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 2'b00, {3'd4, 3'd4}};

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset_vals("reset");

        // Patterns offered in IDLE must not touch any state.
        repeat (3) begin
            bus.pat_valid = 1'b1;
            bus.golden    = 8'($urandom);
            bus.faulty    = 16'($urandom);
            step();
        end
        idle_inputs();
        check_reset_vals("idle_pat");

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            run_session(v.fid, v.mask, v.g, v.f0, v.f1, 1'b0, (i == 1) ? 5 : 0,
                        {v.fid, v.syn, v.det, v.fi}, $sformatf("vec%0d", i));
        end

        v = vecs[1];
        run_session(v.fid, v.mask, v.g, v.f0, v.f1, 1'b1, 2,
                    {v.fid, v.syn, v.det, v.fi}, "gaps");

        // Abandon a session after two patterns.
        bus.start    = 1'b1;
        bus.fault_id = 16'h7777;
        bus.cmp_mask = 8'hFF;
        step();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            bus.pat_valid = 1'b1;
            bus.golden    = 8'h00;
            bus.faulty    = 16'hFFFF;
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("mid_reset");
        run_session(v.fid, v.mask, v.g, v.f0, v.f1, 1'b0, 0,
                    {v.fid, v.syn, v.det, v.fi}, "after_reset");

        for (int n = 0; n < 40; n++) begin
            rfid = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rmask = 8'h00;
                1:       rmask = 8'hFF;
                default: rmask = 8'($urandom);
            endcase
            rg = $urandom;
            for (int k = 0; k < NUM_PAT; k++) begin
                rf0[k*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                rf1[k*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            end
            run_session(rfid, rmask, rg, rf0, rf1, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3), model(rfid, rmask, rg, rf0, rf1),
                        $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
